// File: rtl/casez_pattern_decoder_if.sv
// Bus between a word source and casez_pattern_decoder: qualified 4-bit input word,
// registered class code with its flags, and the optional per-class hit counters.
interface casez_pattern_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [3:0]       in;
    logic [1:0]       out;
    logic             out_valid;
    logic             match;
    logic [CNT_W-1:0] hit_cnt_a;
    logic [CNT_W-1:0] hit_cnt_b;

    modport master (
        output in_valid, in,
        input  out, out_valid, match, hit_cnt_a, hit_cnt_b
    );

    modport slave (
        input  in_valid, in,
        output out, out_valid, match, hit_cnt_a, hit_cnt_b
    );
endinterface

// File: rtl/casez_pattern_decoder.sv
// Registered 4-bit wildcard classifier: 1?00 -> 01, 01?? -> 10, otherwise 00.
// Optional saturating per-class hit counters are built when CASEZ_DECODER_HITCNT_EN is defined.
module casez_pattern_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    casez_pattern_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        CLASS_NONE = 2'b00,
        CLASS_A    = 2'b01,
        CLASS_B    = 2'b10
    } class_e;

    class_e code;

    // NOTE: always_comb assigns a default first, so no path through the casez can infer a latch.
    always_comb begin
        code = CLASS_NONE;
        casez (bus.in)
            4'b1?00: code = CLASS_A;
            4'b01??: code = CLASS_B;
            default: code = CLASS_NONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out       <= CLASS_NONE;
            bus.out_valid <= 1'b0;
            bus.match     <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out   <= code;
                bus.match <= (code != CLASS_NONE);
            end
        end
    end

`ifdef CASEZ_DECODER_HITCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (bus.in_valid) begin
            if (code == CLASS_A && cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
            if (code == CLASS_B && cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
        end
    end

    assign bus.hit_cnt_a = cnt_a;
    assign bus.hit_cnt_b = cnt_b;
`else
    assign bus.hit_cnt_a = '0;
    assign bus.hit_cnt_b = '0;
`endif

endmodule

// File: tb/tb_casez_pattern_decoder.sv
// Directed bench for casez_pattern_decoder; covers the counter feature when
// CASEZ_DECODER_HITCNT_EN is defined, otherwise checks the counters stay at zero.
module tb_casez_pattern_decoder;

`ifdef CASEZ_DECODER_HITCNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    casez_pattern_decoder_if #(.CNT_W(CNT_W)) bus ();

    casez_pattern_decoder #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = 4'b1000;
        step();
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        n_compared++;
        if (bus.out !== 2'b00) begin
            n_mismatched++;
            $display("FAIL reset_out: got %b expected 00", bus.out);
        end
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_compared++;
        if (bus.match !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_match: got %b expected 0", bus.match);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vec   [5] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b1111};
        logic [1:0] exp_o [5] = '{2'b01,   2'b01,   2'b10,   2'b10,   2'b00};
        logic       exp_m [5] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = vec[i];
            step();
            n_compared++;
            if (bus.out !== exp_o[i]) begin
                n_mismatched++;
                $display("FAIL seq_out[%0d]: got %b expected %b", i, bus.out, exp_o[i]);
            end
            n_compared++;
            if (bus.match !== exp_m[i]) begin
                n_mismatched++;
                $display("FAIL seq_match[%0d]: got %b expected %b", i, bus.match, exp_m[i]);
            end
            n_compared++;
            if (bus.out_valid !== 1'b1) begin
                n_mismatched++;
                $display("FAIL seq_out_valid[%0d]: got %b expected 1", i, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_wildcard();
        logic [3:0] vec   [4] = '{4'b1z00, 4'b01z0, 4'b01x0, 4'b1x00};
        logic [1:0] exp_o [4] = '{2'b01,   2'b10,   2'b10,   2'b01};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = vec[i];
            step();
            n_compared++;
            if (bus.out !== exp_o[i]) begin
                n_mismatched++;
                $display("FAIL wild_out[%0d]: got %b expected %b", i, bus.out, exp_o[i]);
            end
        end
        // An x at a care position only exists where the simulator keeps four states.
        bus.in = 4'bx100;
        step();
        if ($isunknown(bus.in)) begin
            n_compared++;
            if (bus.out !== 2'b00) begin
                n_mismatched++;
                $display("FAIL wild_x_care: got %b expected 00", bus.out);
            end
        end
        bus.in_valid = 1'b0;
        bus.in       = 4'b0000;
    endtask

    task automatic test_hold();
        bus.in_valid = 1'b1;
        bus.in       = 4'b0100;
        step();
        bus.in_valid = 1'b0;
        bus.in       = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_compared++;
            if (bus.out !== 2'b10) begin
                n_mismatched++;
                $display("FAIL hold_out[%0d]: got %b expected 10", i, bus.out);
            end
            n_compared++;
            if (bus.out_valid !== 1'b0) begin
                n_mismatched++;
                $display("FAIL hold_out_valid[%0d]: got %b expected 0", i, bus.out_valid);
            end
            n_compared++;
            if (bus.match !== 1'b1) begin
                n_mismatched++;
                $display("FAIL hold_match[%0d]: got %b expected 1", i, bus.match);
            end
        end
    endtask

    task automatic test_reset_wins();
        bus.in_valid = 1'b1;
        bus.in       = 4'b0100;
        step();
        rst    = 1'b1;
        bus.in = 4'b1000;
        step();
        n_compared++;
        if (bus.out !== 2'b00) begin
            n_mismatched++;
            $display("FAIL rst_wins_out: got %b expected 00", bus.out);
        end
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rst_wins_out_valid: got %b expected 0", bus.out_valid);
        end
        n_compared++;
        if (bus.match !== 1'b0) begin
            n_mismatched++;
            $display("FAIL rst_wins_match: got %b expected 0", bus.match);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_counters();
`ifdef CASEZ_DECODER_HITCNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_compared++;
        if (bus.hit_cnt_a !== 2'd0) begin
            n_mismatched++;
            $display("FAIL cnt_a_reset: got %0d expected 0", bus.hit_cnt_a);
        end
        bus.in_valid = 1'b1;
        bus.in       = 4'b1000;
        for (int i = 0; i < 5; i++) step();
        bus.in = 4'b0111;
        step();
        bus.in_valid = 1'b0;
        step();
        n_compared++;
        if (bus.hit_cnt_a !== 2'd3) begin
            n_mismatched++;
            $display("FAIL cnt_a_sat: got %0d expected 3", bus.hit_cnt_a);
        end
        n_compared++;
        if (bus.hit_cnt_b !== 2'd1) begin
            n_mismatched++;
            $display("FAIL cnt_b: got %0d expected 1", bus.hit_cnt_b);
        end
`else
        bus.in_valid = 1'b1;
        bus.in       = 4'b1000;
        step();
        bus.in = 4'b0111;
        step();
        bus.in_valid = 1'b0;
        n_compared++;
        if (bus.hit_cnt_a !== '0) begin
            n_mismatched++;
            $display("FAIL cnt_a_tied: got %0d expected 0", bus.hit_cnt_a);
        end
        n_compared++;
        if (bus.hit_cnt_b !== '0) begin
            n_mismatched++;
            $display("FAIL cnt_b_tied: got %0d expected 0", bus.hit_cnt_b);
        end
`endif
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = 4'b0000;
        #2;
        test_reset();
        test_back_to_back();
        test_wildcard();
        test_hold();
        test_reset_wins();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
